// File: rtl/idex_operand_stage.sv
// ID/EX operand stage: the ID/EX pipeline register with stall and flush,
// MEM/WB operand forwarding, immediate extension, ALUSrc selection and
// load-use stall detection for the pipelined MIPS core.
module idex_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid_d,
  input  logic [WIDTH-1:0]   rd1_d,
  input  logic [WIDTH-1:0]   rd2_d,
  input  logic [15:0]        imm_d,
  input  logic               zeroext_d,
  input  logic [REGBITS-1:0] rs_d,
  input  logic [REGBITS-1:0] rt_d,
  input  logic [REGBITS-1:0] rd_d,
  input  logic [2:0]         alucontrol_d,
  input  logic               alusrc_d,
  input  logic               regdst_d,
  input  logic               regwrite_d,
  input  logic               memtoreg_d,
  input  logic               memwrite_d,
  input  logic               stall_e,
  input  logic               flush_e,
  input  logic [WIDTH-1:0]   aluout_m,
  input  logic [REGBITS-1:0] writereg_m,
  input  logic               regwrite_m,
  input  logic [WIDTH-1:0]   result_w,
  input  logic [REGBITS-1:0] writereg_w,
  input  logic               regwrite_w,
  output logic [WIDTH-1:0]   srca_e,
  output logic [WIDTH-1:0]   srcb_e,
  output logic [2:0]         alucontrol_e,
  output logic [WIDTH-1:0]   writedata_e,
  output logic [REGBITS-1:0] writereg_e,
  output logic               regwrite_e,
  output logic               memtoreg_e,
  output logic               memwrite_e,
  output logic               valid_e,
  output logic [1:0]         fwda_e,
  output logic [1:0]         fwdb_e,
  output logic               lwstall_d
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;
    logic [WIDTH-1:0]   imm;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] rd;
    logic [2:0]         alucontrol;
    logic               alusrc;
    logic               regdst;
    logic               regwrite;
    logic               memtoreg;
    logic               memwrite;
    logic               valid;
  } idex_t;

  idex_t            ex_d;
  idex_t            ex_q;
  logic [WIDTH-1:0] imm_ext_d;

  // Forward select for one source register; MEM wins over WB, $0 never forwards.
  function automatic logic [1:0] fwd_select(
    input logic               valid,
    input logic [REGBITS-1:0] src,
    input logic               wr_m,
    input logic [REGBITS-1:0] dst_m,
    input logic               wr_w,
    input logic [REGBITS-1:0] dst_w
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (!valid || (src == {REGBITS{1'b0}})) begin
      sel = FWD_REG;
    end else if (wr_m && (dst_m == src)) begin
      sel = FWD_MEM;
    end else if (wr_w && (dst_w == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

  // Operand mux driven by a forward select.
  function automatic logic [WIDTH-1:0] fwd_mux(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] reg_val,
    input logic [WIDTH-1:0] mem_val,
    input logic [WIDTH-1:0] wb_val
  );
    logic [WIDTH-1:0] val;
    case (sel)
      FWD_MEM: val = mem_val;
      FWD_WB:  val = wb_val;
      default: val = reg_val;
    endcase
    return val;
  endfunction

  // Extend the raw immediate before it enters the pipeline register.
  always_comb begin
    imm_ext_d = {WIDTH{1'b0}};
    if (zeroext_d) begin
      imm_ext_d = {{(WIDTH-16){1'b0}}, imm_d};
    end else begin
      imm_ext_d = {{(WIDTH-16){imm_d[15]}}, imm_d};
    end
  end

  // Next E-register contents: flush bubble beats stall hold beats load.
  always_comb begin
    ex_d = ex_q;
    if (flush_e) begin
      ex_d = '0;
    end else if (stall_e) begin
      ex_d = ex_q;
    end else begin
      ex_d.rd1        = rd1_d;
      ex_d.rd2        = rd2_d;
      ex_d.imm        = imm_ext_d;
      ex_d.rs         = rs_d;
      ex_d.rt         = rt_d;
      ex_d.rd         = rd_d;
      ex_d.alucontrol = alucontrol_d;
      ex_d.alusrc     = alusrc_d;
      ex_d.regdst     = regdst_d;
      ex_d.regwrite   = regwrite_d;
      ex_d.memtoreg   = memtoreg_d;
      ex_d.memwrite   = memwrite_d;
      ex_d.valid      = valid_d;
    end
  end

  // ID/EX pipeline register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Forwarding, operand selection, destination choice and load-use detection.
  always_comb begin
    fwda_e       = fwd_select(ex_q.valid, ex_q.rs, regwrite_m, writereg_m,
                              regwrite_w, writereg_w);
    fwdb_e       = fwd_select(ex_q.valid, ex_q.rt, regwrite_m, writereg_m,
                              regwrite_w, writereg_w);
    srca_e       = fwd_mux(fwda_e, ex_q.rd1, aluout_m, result_w);
    writedata_e  = fwd_mux(fwdb_e, ex_q.rd2, aluout_m, result_w);
    srcb_e       = ex_q.alusrc ? ex_q.imm : writedata_e;
    writereg_e   = ex_q.regdst ? ex_q.rd : ex_q.rt;
    alucontrol_e = ex_q.alucontrol;
    regwrite_e   = ex_q.regwrite;
    memtoreg_e   = ex_q.memtoreg;
    memwrite_e   = ex_q.memwrite;
    valid_e      = ex_q.valid;
    lwstall_d    = ex_q.valid & ex_q.memtoreg & valid_d
                 & ((ex_q.rt == rs_d) | (ex_q.rt == rt_d))
                 & (ex_q.rt != {REGBITS{1'b0}});
  end

endmodule

// File: tb/tb_idex_operand_stage.sv
// Self-checking bench for idex_operand_stage: directed scenarios plus
// randomized traffic compared against a behavioural model of the E stage.
module tb_idex_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n, valid_d, zeroext_d, alusrc_d, regdst_d;
  logic        regwrite_d, memtoreg_d, memwrite_d, stall_e, flush_e;
  logic [31:0] rd1_d, rd2_d, aluout_m, result_w;
  logic [15:0] imm_d;
  logic [4:0]  rs_d, rt_d, rd_d, writereg_m, writereg_w;
  logic [2:0]  alucontrol_d;
  logic        regwrite_m, regwrite_w;
  logic [31:0] srca_e, srcb_e, writedata_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  writereg_e;
  logic        regwrite_e, memtoreg_e, memwrite_e, valid_e, lwstall_d;
  logic [1:0]  fwda_e, fwdb_e;

  int total = 0;
  int bad   = 0;

  // Model of the instruction currently in E.
  logic        m_valid, m_alusrc, m_regdst, m_regw, m_mtr, m_memw;
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [2:0]  m_alu;

  // Expected outputs derived from the model.
  logic [31:0] e_srca, e_srcb, e_wd;
  logic [1:0]  e_fwda, e_fwdb;
  logic [4:0]  e_wr;
  logic        e_lw;

  idex_operand_stage #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .reset_n(reset_n), .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_d(imm_d), .zeroext_d(zeroext_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d), .regdst_d(regdst_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
    .stall_e(stall_e), .flush_e(flush_e), .aluout_m(aluout_m), .writereg_m(writereg_m),
    .regwrite_m(regwrite_m), .result_w(result_w), .writereg_w(writereg_w),
    .regwrite_w(regwrite_w), .srca_e(srca_e), .srcb_e(srcb_e), .alucontrol_e(alucontrol_e),
    .writedata_e(writedata_e), .writereg_e(writereg_e), .regwrite_e(regwrite_e),
    .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e), .valid_e(valid_e),
    .fwda_e(fwda_e), .fwdb_e(fwdb_e), .lwstall_d(lwstall_d)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (!m_valid || r == 5'd0) return 2'b00;
    if (regwrite_m && writereg_m == r) return 2'b10;
    if (regwrite_w && writereg_w == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_val(input logic [1:0] sel, input logic [31:0] regv);
    if (sel == 2'b10) return aluout_m;
    if (sel == 2'b01) return result_w;
    return regv;
  endfunction

  // Advance the model by the clock edge about to happen.
  task automatic model_edge();
    if (!reset_n || flush_e) begin
      {m_valid, m_alusrc, m_regdst, m_regw, m_mtr, m_memw} = 6'd0;
      m_rd1 = 32'd0; m_rd2 = 32'd0; m_imm = 32'd0;
      m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_alu = 3'd0;
    end else if (!stall_e) begin
      m_valid = valid_d; m_alusrc = alusrc_d; m_regdst = regdst_d;
      m_regw = regwrite_d; m_mtr = memtoreg_d; m_memw = memwrite_d;
      m_rd1 = rd1_d; m_rd2 = rd2_d;
      m_imm = zeroext_d ? 32'(imm_d) : 32'($signed(imm_d));
      m_rs = rs_d; m_rt = rt_d; m_rd = rd_d; m_alu = alucontrol_d;
    end
  endtask

  task automatic model_outputs();
    e_fwda = exp_fwd(m_rs);
    e_fwdb = exp_fwd(m_rt);
    e_srca = exp_val(e_fwda, m_rd1);
    e_wd   = exp_val(e_fwdb, m_rd2);
    e_srcb = m_alusrc ? m_imm : e_wd;
    e_wr   = m_regdst ? m_rd : m_rt;
    e_lw   = m_valid && m_mtr && valid_d && (m_rt == rs_d || m_rt == rt_d) && m_rt != 5'd0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_d(input int regmax);
    valid_d = 1'($urandom); rd1_d = $urandom; rd2_d = $urandom; imm_d = 16'($urandom);
    zeroext_d = 1'($urandom); rs_d = 5'($urandom_range(regmax)); rt_d = 5'($urandom_range(regmax));
    rd_d = 5'($urandom_range(regmax)); alucontrol_d = 3'($urandom); alusrc_d = 1'($urandom);
    regdst_d = 1'($urandom); regwrite_d = 1'($urandom); memtoreg_d = 1'($urandom);
    memwrite_d = 1'($urandom);
  endtask

  task automatic rand_mw(input int regmax);
    aluout_m = $urandom; result_w = $urandom;
    writereg_m = 5'($urandom_range(regmax)); writereg_w = 5'($urandom_range(regmax));
    regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    rand_d(31); rand_mw(31);
    tick(); rand_d(31); tick();
    total++;
    if ({srca_e, srcb_e, writedata_e} !== 96'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", srca_e, srcb_e, writedata_e);
    end
    total++;
    if ({alucontrol_e, writereg_e, regwrite_e, memtoreg_e, memwrite_e, valid_e, fwda_e, fwdb_e, lwstall_d} !== 17'd0) begin
      bad++; $display("FAIL reset_ctrl got alu=%b wr=%0d rw=%b mtr=%b mw=%b v=%b fa=%b fb=%b lw=%b want=0",
        alucontrol_e, writereg_e, regwrite_e, memtoreg_e, memwrite_e, valid_e, fwda_e, fwdb_e, lwstall_d);
    end
    reset_n = 1'b1; rand_d(31);
    valid_d = 1'b1; rd1_d = 32'd5; rd2_d = 32'd7; alucontrol_d = 3'b010; alusrc_d = 1'b0;
    regwrite_m = 1'b0; regwrite_w = 1'b0;
    tick();
    total++;
    if (srca_e !== 32'd5 || srcb_e !== 32'd7) begin
      bad++; $display("FAIL release_ops got a=%0d b=%0d want a=5 b=7", srca_e, srcb_e);
    end
    total++;
    if (alucontrol_e !== 3'b010 || valid_e !== 1'b1) begin
      bad++; $display("FAIL release_ctrl got alu=%b v=%b want 010/1", alucontrol_e, valid_e);
    end
  endtask

  task automatic test_immediate();
    regwrite_m = 1'b0; regwrite_w = 1'b0;
    valid_d = 1'b1; imm_d = 16'h8001; alusrc_d = 1'b1; zeroext_d = 1'b0;
    tick();
    total++;
    if (srcb_e !== 32'hFFFF8001) begin
      bad++; $display("FAIL imm_sign got=%h want=ffff8001", srcb_e);
    end
    zeroext_d = 1'b1;
    tick();
    total++;
    if (srcb_e !== 32'h00008001) begin
      bad++; $display("FAIL imm_zero got=%h want=00008001", srcb_e);
    end
    for (int i = 0; i < 16; i++) begin
      rand_d(31); alusrc_d = 1'b1;
      tick(); model_outputs();
      total++;
      if (srcb_e !== e_srcb) begin
        bad++; $display("FAIL imm_rand imm=%h zx=%b got=%h want=%h", imm_d, zeroext_d, srcb_e, e_srcb);
      end
    end
  endtask

  task automatic test_forwarding();
    rand_d(31);
    valid_d = 1'b1; rs_d = 5'd3; rt_d = 5'd3; alusrc_d = 1'b0;
    rd1_d = 32'h100; rd2_d = 32'h200;
    regwrite_m = 1'b0; regwrite_w = 1'b0;
    tick();
    writereg_m = 5'd3; writereg_w = 5'd3; regwrite_m = 1'b1; regwrite_w = 1'b1;
    aluout_m = 32'd11; result_w = 32'd22;
    #1;
    total++;
    if (srca_e !== 32'd11 || writedata_e !== 32'd11 || fwda_e !== 2'b10 || fwdb_e !== 2'b10) begin
      bad++; $display("FAIL fwd_mem got a=%0d wd=%0d fa=%b fb=%b want 11/11/10/10", srca_e, writedata_e, fwda_e, fwdb_e);
    end
    regwrite_m = 1'b0;
    #1;
    total++;
    if (srca_e !== 32'd22 || writedata_e !== 32'd22 || fwda_e !== 2'b01) begin
      bad++; $display("FAIL fwd_wb got a=%0d wd=%0d fa=%b want 22/22/01", srca_e, writedata_e, fwda_e);
    end
    regwrite_m = 1'b1; writereg_m = 5'd0; writereg_w = 5'd0;
    #1;
    total++;
    if (srca_e !== 32'h100 || writedata_e !== 32'h200 || fwda_e !== 2'b00 || fwdb_e !== 2'b00) begin
      bad++; $display("FAIL fwd_none got a=%h wd=%h fa=%b fb=%b want 100/200/00/00", srca_e, writedata_e, fwda_e, fwdb_e);
    end
    for (int i = 0; i < 40; i++) begin
      rand_d(3);
      tick();
      rand_mw(3);
      #1;
      model_outputs();
      total++;
      if (fwda_e !== e_fwda || fwdb_e !== e_fwdb) begin
        bad++; $display("FAIL fwd_sel_rand got %b/%b want %b/%b", fwda_e, fwdb_e, e_fwda, e_fwdb);
      end
      total++;
      if (srca_e !== e_srca || writedata_e !== e_wd || srcb_e !== e_srcb) begin
        bad++; $display("FAIL fwd_val_rand got %h/%h/%h want %h/%h/%h", srca_e, writedata_e, srcb_e, e_srca, e_wd, e_srcb);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] x_a, x_b;
    logic [2:0]  x_alu;
    regwrite_m = 1'b0; regwrite_w = 1'b0;
    rand_d(31); valid_d = 1'b1; regwrite_d = 1'b1; memwrite_d = 1'b1; alusrc_d = 1'b0;
    x_a = rd1_d; x_b = rd2_d; x_alu = alucontrol_d;
    tick();
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d(31);
      tick();
      total++;
      if (srca_e !== x_a || srcb_e !== x_b || alucontrol_e !== x_alu || valid_e !== 1'b1) begin
        bad++; $display("FAIL stall_hold cyc=%0d got %h/%h/%b/%b want %h/%h/%b/1",
          i, srca_e, srcb_e, alucontrol_e, valid_e, x_a, x_b, x_alu);
      end
    end
    flush_e = 1'b1; rand_d(31); valid_d = 1'b1; regwrite_d = 1'b1; memwrite_d = 1'b1;
    tick();
    total++;
    if (valid_e !== 1'b0 || regwrite_e !== 1'b0 || memwrite_e !== 1'b0 || memtoreg_e !== 1'b0) begin
      bad++; $display("FAIL flush_bubble got v=%b rw=%b mw=%b mtr=%b want 0", valid_e, regwrite_e, memwrite_e, memtoreg_e);
    end
    stall_e = 1'b0; flush_e = 1'b0;
  endtask

  task automatic test_load_use();
    logic [4:0] rts [3] = '{5'd4, 5'd0, 5'd4};
    logic       vds [3] = '{1'b1, 1'b1, 1'b0};
    logic       want[3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      rand_d(31); valid_d = vds[i]; memtoreg_d = 1'b1; rt_d = rts[i];
      tick();
      stall_e = 1'b1; valid_d = 1'b1; rs_d = rts[i]; rt_d = 5'd7;
      #1;
      total++;
      if (lwstall_d !== want[i]) begin
        bad++; $display("FAIL load_use case=%0d got=%b want=%b", i, lwstall_d, want[i]);
      end
      stall_e = 1'b0;
    end
  endtask

  task automatic test_destination();
    rand_d(31); regdst_d = 1'b1; rd_d = 5'd9; rt_d = 5'd2;
    tick();
    total++;
    if (writereg_e !== 5'd9) begin
      bad++; $display("FAIL dest_rd got=%0d want=9", writereg_e);
    end
    regdst_d = 1'b0;
    tick();
    total++;
    if (writereg_e !== 5'd2) begin
      bad++; $display("FAIL dest_rt got=%0d want=2", writereg_e);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_d(7); rand_mw(7);
      reset_n = ($urandom_range(31) != 0);
      stall_e = ($urandom_range(5) == 0);
      flush_e = ($urandom_range(7) == 0);
      tick();
      reset_n = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
      rand_mw(7); rand_d(7);
      #1;
      model_outputs();
      total++;
      if (srca_e !== e_srca || srcb_e !== e_srcb || writedata_e !== e_wd) begin
        bad++; $display("FAIL rand_data i=%0d got %h/%h/%h want %h/%h/%h", i, srca_e, srcb_e, writedata_e, e_srca, e_srcb, e_wd);
      end
      total++;
      if (fwda_e !== e_fwda || fwdb_e !== e_fwdb || writereg_e !== e_wr || lwstall_d !== e_lw) begin
        bad++; $display("FAIL rand_sel i=%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", i, fwda_e, fwdb_e, writereg_e, lwstall_d, e_fwda, e_fwdb, e_wr, e_lw);
      end
      total++;
      if ({alucontrol_e, regwrite_e, memtoreg_e, memwrite_e, valid_e} !== {m_alu, m_regw, m_mtr, m_memw, m_valid}) begin
        bad++; $display("FAIL rand_ctrl i=%0d got %b%b%b%b%b want %b%b%b%b%b", i, alucontrol_e, regwrite_e, memtoreg_e, memwrite_e, valid_e, m_alu, m_regw, m_mtr, m_memw, m_valid);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    rand_d(31); rand_mw(31);
    #2;
    test_reset();
    test_immediate();
    test_forwarding();
    test_stall_flush();
    test_load_use();
    test_destination();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
